// File: rtl/sram_pkg.sv
// Shared types and constants for the SRAM arbiter slice: bus widths,
// default config-byte address and the arbiter state encoding.
package sram_pkg;

  localparam int ADDR_W = 19;
  localparam int DATA_W = 8;

  localparam logic [ADDR_W-1:0] DEFAULT_CFG_ADDR = 19'h08FD5;

  typedef enum logic [2:0] {
    ST_BOOT,
    ST_IDLE,
    ST_RD,
    ST_WR_SETUP,
    ST_WR_PULSE,
    ST_WR_HOLD
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sram_hold_timer.sv
// Reloadable down-counter that keeps the arcade core in reset while the
// loader is writing and for HOLD_CYCLES clocks after its last write.
module sram_hold_timer #(
  parameter int HOLD_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic reload,
  input  logic enable,
  output logic core_hold
);

  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES);

  logic [CNT_W-1:0] count;
  logic             loading;

  // The count is frozen while a write is in flight and only runs once the
  // boot config read has finished, so the first release is timed from cfg_valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= HOLD_LOAD;
      loading <= 1'b0;
    end else if (reload) begin
      count   <= HOLD_LOAD;
      loading <= 1'b0;
    end else if (start) begin
      loading <= 1'b1;
    end else if (!loading && enable && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign core_hold = loading || !enable || (count != '0);

endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: sole owner of the external SRAM bus. Boot config read, then
// loader writes (priority) and arcade ROM fetches; all SRAM pins registered.
module sram_arbiter
  import sram_pkg::*;
#(
  parameter logic [ADDR_W-1:0] CFG_ADDR    = DEFAULT_CFG_ADDR,
  parameter int                RD_CYCLES   = 2,
  parameter int                WE_CYCLES   = 2,
  parameter int                HOLD_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ldr_req,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_data,
  output logic              ldr_ack,
  input  logic [ADDR_W-1:0] core_addr,
  output logic [DATA_W-1:0] core_data,
  output logic              core_valid,
  output logic              core_hold,
  output logic [DATA_W-1:0] cfg_data,
  output logic              cfg_valid,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_dout,
  output logic              sram_doe,
  input  logic [DATA_W-1:0] sram_din,
  output logic              sram_we_n
);

  localparam int CNT_W = $clog2(max_int(RD_CYCLES, WE_CYCLES) + 1);
  localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'(RD_CYCLES);
  localparam logic [CNT_W-1:0] RD_LAST   = CNT_W'(RD_CYCLES - 1);
  localparam logic [CNT_W-1:0] WE_LAST   = CNT_W'(WE_CYCLES - 1);

  state_t            state, state_next;
  logic [CNT_W-1:0]  cnt, cnt_next;

  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] dout_d, core_data_d, cfg_data_d;
  logic              doe_d, we_n_d, ack_d, core_valid_d, cfg_valid_d;
  logic              hold_start;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_BOOT;
      cnt        <= '0;
      sram_addr  <= CFG_ADDR;
      sram_dout  <= '0;
      sram_doe   <= 1'b0;
      sram_we_n  <= 1'b1;
      ldr_ack    <= 1'b0;
      core_data  <= '0;
      core_valid <= 1'b0;
      cfg_data   <= '0;
      cfg_valid  <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      sram_addr  <= addr_d;
      sram_dout  <= dout_d;
      sram_doe   <= doe_d;
      sram_we_n  <= we_n_d;
      ldr_ack    <= ack_d;
      core_data  <= core_data_d;
      core_valid <= core_valid_d;
      cfg_data   <= cfg_data_d;
      cfg_valid  <= cfg_valid_d;
    end
  end

  // The boot wait lasts one clock longer than a fetch's RD phase because the
  // config address is already on the pins out of reset.
  always_comb begin
    state_next = state;
    cnt_next   = cnt + 1'b1;
    case (state)
      ST_BOOT: begin
        if (cnt == BOOT_LAST) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end
      end
      ST_IDLE: begin
        cnt_next   = '0;
        state_next = ldr_req ? ST_WR_SETUP : ST_RD;
      end
      ST_RD: begin
        if (cnt == RD_LAST) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end
      end
      ST_WR_SETUP: begin
        state_next = ST_WR_PULSE;
        cnt_next   = '0;
      end
      ST_WR_PULSE: begin
        if (cnt == WE_LAST) begin
          state_next = ST_WR_HOLD;
          cnt_next   = '0;
        end
      end
      ST_WR_HOLD: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
      default: begin
        state_next = ST_BOOT;
        cnt_next   = '0;
      end
    endcase
  end

  always_comb begin
    addr_d       = sram_addr;
    dout_d       = sram_dout;
    doe_d        = sram_doe;
    we_n_d       = 1'b1;
    ack_d        = 1'b0;
    core_data_d  = core_data;
    core_valid_d = 1'b0;
    cfg_data_d   = cfg_data;
    cfg_valid_d  = cfg_valid;
    case (state)
      ST_BOOT: begin
        if (cnt == BOOT_LAST) begin
          cfg_data_d  = sram_din;
          cfg_valid_d = 1'b1;
        end
      end
      ST_IDLE: begin
        doe_d = ldr_req;
        if (ldr_req) begin
          addr_d = ldr_addr;
          dout_d = ldr_data;
        end else begin
          addr_d = core_addr;
        end
      end
      ST_RD: begin
        if (cnt == RD_LAST) begin
          core_data_d  = sram_din;
          core_valid_d = 1'b1;
        end
      end
      ST_WR_SETUP: we_n_d = 1'b0;
      ST_WR_PULSE: begin
        if (cnt == WE_LAST) ack_d = 1'b1;
        else                we_n_d = 1'b0;
      end
      ST_WR_HOLD: doe_d = 1'b0;
      default: ;
    endcase
  end

  assign hold_start = (state == ST_IDLE) && ldr_req;

  sram_hold_timer #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_hold_timer (
    .clk      (clk),
    .reset    (reset),
    .start    (hold_start),
    .reload   (ack_d),
    .enable   (cfg_valid),
    .core_hold(core_hold)
  );

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter with a behavioural SRAM model and
// expectations derived from the arbiter's timing rules.
module tb_sram_arbiter;

  localparam logic [18:0] CFG  = 19'h08FD5;
  localparam int          RD   = 2;
  localparam int          WE   = 2;
  localparam int          HOLD = 255;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, ldr_req, ldr_ack, core_valid, core_hold, cfg_valid;
  logic        sram_doe, sram_we_n;
  logic [18:0] ldr_addr, core_addr, sram_addr;
  logic [7:0]  ldr_data, core_data, cfg_data, sram_dout, sram_din;

  logic [7:0]  mem [0:524287];
  logic        pl_en;
  logic [18:0] pl_addr;
  logic [7:0]  pl_data;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int cfg_cyc = 0;

  sram_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .ldr_req   (ldr_req),
    .ldr_addr  (ldr_addr),
    .ldr_data  (ldr_data),
    .ldr_ack   (ldr_ack),
    .core_addr (core_addr),
    .core_data (core_data),
    .core_valid(core_valid),
    .core_hold (core_hold),
    .cfg_data  (cfg_data),
    .cfg_valid (cfg_valid),
    .sram_addr (sram_addr),
    .sram_dout (sram_dout),
    .sram_doe  (sram_doe),
    .sram_din  (sram_din),
    .sram_we_n (sram_we_n)
  );

  // Asynchronous SRAM: reads follow the address, writes land while we_n is low.
  assign sram_din = mem[sram_addr];
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (!sram_we_n && sram_doe) mem[sram_addr] <= sram_dout;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic preload(input logic [18:0] a, input logic [7:0] d);
    pl_addr = a;
    pl_data = d;
    pl_en   = 1'b1;
    tick();
    pl_en   = 1'b0;
  endtask

  task automatic wait_valid(input int n, output bit ok);
    int seen = 0;
    for (int i = 0; i < 60 && seen < n; i++) begin
      tick();
      if (core_valid) seen++;
    end
    ok = (seen == n);
  endtask

  task automatic test_reset();
    int n = 0;
    bit we_ok = 1'b1;
    reset = 1'b1;
    preload(CFG, 8'h05);
    preload(19'h00123, 8'hA7);
    tick();
    total++; if (sram_addr !== CFG) begin bad++; $display("[TB] FAIL rst_addr: got %h want %h", sram_addr, CFG); end
    total++; if (sram_we_n !== 1'b1 || sram_doe !== 1'b0 || sram_dout !== 8'h00) begin bad++; $display("[TB] FAIL rst_wr_pins: got we_n=%b doe=%b dout=%h want 1 0 00", sram_we_n, sram_doe, sram_dout); end
    total++; if (ldr_ack !== 1'b0 || core_valid !== 1'b0 || core_data !== 8'h00) begin bad++; $display("[TB] FAIL rst_core: got ack=%b valid=%b data=%h want 0 0 00", ldr_ack, core_valid, core_data); end
    total++; if (core_hold !== 1'b1 || cfg_valid !== 1'b0 || cfg_data !== 8'h00) begin bad++; $display("[TB] FAIL rst_cfg: got hold=%b cfg_valid=%b cfg_data=%h want 1 0 00", core_hold, cfg_valid, cfg_data); end
    reset = 1'b0;
    while (!cfg_valid && n < 20) begin
      tick();
      n++;
      if (!sram_we_n) we_ok = 1'b0;
    end
    cfg_cyc = cyc;
    total++; if (n != RD + 1) begin bad++; $display("[TB] FAIL cfg_latency: got %0d want %0d", n, RD + 1); end
    total++; if (cfg_data !== 8'h05) begin bad++; $display("[TB] FAIL cfg_data: got %h want 05", cfg_data); end
    total++; if (!we_ok) begin bad++; $display("[TB] FAIL boot_we_n: got low pulse want none"); end
  endtask

  task automatic test_core_fetch();
    int last = -1;
    int pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (core_valid) begin
        if (last >= 0) begin
          total++; if (cyc - last != RD + 1) begin bad++; $display("[TB] FAIL fetch_period: got %0d want %0d", cyc - last, RD + 1); end
        end
        total++; if (core_data !== 8'hA7) begin bad++; $display("[TB] FAIL fetch_data: got %h want a7", core_data); end
        last = cyc;
        pulses++;
      end
    end
    total++; if (pulses < 5) begin bad++; $display("[TB] FAIL fetch_count: got %0d want >=5", pulses); end
  endtask

  task automatic test_hold_release();
    int n = 0;
    while (core_hold && n < 400) begin tick(); n++; end
    total++; if (core_hold !== 1'b0 || cyc - cfg_cyc != HOLD) begin bad++; $display("[TB] FAIL boot_hold: got hold=%b after %0d want 0 after %0d", core_hold, cyc - cfg_cyc, HOLD); end
  endtask

  task automatic test_random_fetch();
    bit ok;
    for (int i = 0; i < 8; i++) begin
      logic [18:0] a;
      logic [7:0]  d;
      a = 19'($urandom_range(32'h10000, 32'h7FFFF));
      d = 8'($urandom_range(0, 255));
      preload(a, d);
      core_addr = a;
      wait_valid(2, ok);
      total++; if (!ok || core_data !== d) begin bad++; $display("[TB] FAIL rand_fetch: addr %h got %h ok=%0d want %h", a, core_data, ok, d); end
    end
  endtask

  task automatic test_single_write();
    int stable = 0, wel = 0, acks = 0, doeh = 0;
    bit ok;
    core_addr = 19'h00123;
    ldr_addr  = 19'h01000;
    ldr_data  = 8'h3C;
    ldr_req   = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (sram_addr == 19'h01000 && sram_dout == 8'h3C) stable++;
      if (!sram_we_n) wel++;
      if (sram_doe) doeh++;
      if (ldr_ack) begin
        acks++;
        ldr_req = 1'b0;
        total++; if (sram_we_n !== 1'b1 || sram_doe !== 1'b1) begin bad++; $display("[TB] FAIL ack_phase: got we_n=%b doe=%b want 1 1", sram_we_n, sram_doe); end
      end
    end
    total++; if (stable != WE + 3) begin bad++; $display("[TB] FAIL wr_stable: got %0d want %0d", stable, WE + 3); end
    total++; if (wel != WE) begin bad++; $display("[TB] FAIL wr_we_low: got %0d want %0d", wel, WE); end
    total++; if (doeh != WE + 2) begin bad++; $display("[TB] FAIL wr_doe: got %0d want %0d", doeh, WE + 2); end
    total++; if (acks != 1) begin bad++; $display("[TB] FAIL wr_ack_count: got %0d want 1", acks); end
    core_addr = 19'h01000;
    wait_valid(2, ok);
    total++; if (!ok || core_data !== 8'h3C) begin bad++; $display("[TB] FAIL wr_readback: got %h ok=%0d want 3c", core_data, ok); end
  endtask

  task automatic test_back_to_back();
    logic [18:0] wa [4];
    logic [7:0]  wd [4];
    int ack_cyc [4];
    int k = 0, between = 0, n = 0;
    bit ok;
    for (int i = 0; i < 4; i++) begin
      wa[i] = 19'(32'h40000 + i * 256 + $urandom_range(0, 255));
      wd[i] = 8'($urandom_range(0, 255));
    end
    core_addr = 19'h00123;
    ldr_addr  = wa[0];
    ldr_data  = wd[0];
    ldr_req   = 1'b1;
    for (int i = 0; i < 80 && k < 4; i++) begin
      tick();
      if (core_valid && k > 0) between++;
      if (ldr_ack) begin
        ack_cyc[k] = cyc;
        k++;
        if (k < 4) begin ldr_addr = wa[k]; ldr_data = wd[k]; end
        else ldr_req = 1'b0;
      end
    end
    ldr_req = 1'b0;
    total++; if (k != 4) begin bad++; $display("[TB] FAIL b2b_timeout: got %0d acks want 4", k); end
    if (k == 4) begin
      for (int j = 1; j < 4; j++) begin
        total++; if (ack_cyc[j] - ack_cyc[j-1] != WE + 3) begin bad++; $display("[TB] FAIL b2b_spacing: got %0d want %0d", ack_cyc[j] - ack_cyc[j-1], WE + 3); end
      end
      total++; if (between != 0) begin bad++; $display("[TB] FAIL b2b_fetch: got %0d fetches want 0", between); end
      while (core_hold && n < 400) begin tick(); n++; end
      total++; if (core_hold !== 1'b0 || cyc - ack_cyc[3] != HOLD) begin bad++; $display("[TB] FAIL b2b_hold: got hold=%b after %0d want 0 after %0d", core_hold, cyc - ack_cyc[3], HOLD); end
    end
    for (int j = 0; j < 4; j++) begin
      core_addr = wa[j];
      wait_valid(2, ok);
      total++; if (!ok || core_data !== wd[j]) begin bad++; $display("[TB] FAIL b2b_readback: addr %h got %h want %h", wa[j], core_data, wd[j]); end
    end
  endtask

  task automatic test_req_mid_rd();
    int n = 0, a, vcyc = -1, dcyc = -1;
    logic doe_at_valid = 1'b1;
    logic [18:0] wa;
    logic [7:0]  wd;
    bit done = 1'b0, ok;
    core_addr = 19'h00123;
    while (!core_valid && n < 20) begin tick(); n++; end
    tick();
    wa = 19'(32'h60000 + $urandom_range(0, 4095));
    wd = 8'($urandom_range(0, 255));
    ldr_addr = wa;
    ldr_data = wd;
    ldr_req  = 1'b1;
    a = cyc;
    for (int i = 0; i < 20 && !done; i++) begin
      tick();
      if (core_valid && vcyc < 0) begin vcyc = cyc; doe_at_valid = sram_doe; end
      if (sram_doe && dcyc < 0) dcyc = cyc;
      if (ldr_ack) begin ldr_req = 1'b0; done = 1'b1; end
    end
    ldr_req = 1'b0;
    total++; if (vcyc < 0 || doe_at_valid !== 1'b0) begin bad++; $display("[TB] FAIL midrd_valid: got vcyc=%0d doe=%b want pulse with doe 0", vcyc, doe_at_valid); end
    total++; if (dcyc != vcyc + 1) begin bad++; $display("[TB] FAIL midrd_setup: got %0d want %0d", dcyc, vcyc + 1); end
    total++; if (dcyc - a > RD + 1 || dcyc < 0) begin bad++; $display("[TB] FAIL midrd_latency: got %0d want <=%0d", dcyc - a, RD + 1); end
    core_addr = wa;
    wait_valid(2, ok);
    total++; if (!ok || core_data !== wd) begin bad++; $display("[TB] FAIL midrd_readback: got %h want %h", core_data, wd); end
  endtask

  task automatic test_reset_mid_write();
    int n = 0, acks = 0;
    logic [7:0] nb;
    nb = 8'($urandom_range(0, 255)) ^ 8'h80;
    if (nb == 8'h05) nb = 8'h5A;
    core_addr = 19'h00123;
    preload(CFG, nb);
    ldr_addr = 19'(32'h70000 + $urandom_range(0, 4095));
    ldr_data = 8'($urandom_range(0, 255));
    ldr_req  = 1'b1;
    while (sram_we_n && n < 20) begin tick(); n++; end
    total++; if (sram_we_n !== 1'b0) begin bad++; $display("[TB] FAIL rmw_timeout: got we_n=%b want 0", sram_we_n); end
    reset = 1'b1;
    tick();
    total++; if (sram_we_n !== 1'b1 || sram_doe !== 1'b0) begin bad++; $display("[TB] FAIL rmw_pins: got we_n=%b doe=%b want 1 0", sram_we_n, sram_doe); end
    total++; if (sram_addr !== CFG || cfg_valid !== 1'b0 || core_hold !== 1'b1) begin bad++; $display("[TB] FAIL rmw_boot: got addr=%h cfg_valid=%b hold=%b want %h 0 1", sram_addr, cfg_valid, core_hold, CFG); end
    total++; if (ldr_ack !== 1'b0) begin bad++; $display("[TB] FAIL rmw_ack: got %b want 0", ldr_ack); end
    ldr_req = 1'b0;
    tick();
    reset = 1'b0;
    n = 0;
    while (!cfg_valid && n < 20) begin
      tick();
      n++;
      if (ldr_ack) acks++;
    end
    total++; if (n != RD + 1 || cfg_data !== nb) begin bad++; $display("[TB] FAIL rmw_reread: got %0d clks data %h want %0d clks data %h", n, cfg_data, RD + 1, nb); end
    total++; if (acks != 0) begin bad++; $display("[TB] FAIL rmw_late_ack: got %0d want 0", acks); end
  endtask

  initial begin
    reset     = 1'b1;
    ldr_req   = 1'b0;
    ldr_addr  = '0;
    ldr_data  = '0;
    core_addr = 19'h00123;
    pl_en     = 1'b0;
    pl_addr   = '0;
    pl_data   = '0;
    test_reset();
    test_core_fetch();
    test_hold_release();
    test_random_fetch();
    test_single_write();
    test_back_to_back();
    test_req_mid_rd();
    test_reset_mid_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish want finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
Single owner of the external 8-bit SRAM bus (19-bit address, shared data, active-low WE) for the arcade ports.
Serialises three users onto that bus:
- a one-shot power-on read of the scan-doubler config byte;
- ROM-loader writes from the control module;
- continuous ROM fetches from the arcade core.
Also generates the core hold-in-reset while loading is in progress.
Sits between the control module / arcade core and the board SRAM pins in the top level.

Parameters:
CFG_ADDR, 19'h08FD5, address of the video config byte read once after reset
RD_CYCLES, 2, clocks the address is held before read data is sampled (>=1)
WE_CYCLES, 2, clocks sram_we_n is held low per write (>=1)
HOLD_CYCLES, 255, clocks core_hold stays high after the last loader write (>=1)

Ports:
clk  in  1  arbiter clock; the loader clock domain, 50 MHz class
reset  in  1  synchronous, active-high
ldr_req  in  1  loader write request; level, held until ldr_ack
ldr_addr  in  19  loader write address; stable while ldr_req=1
ldr_data  in  8  loader write data; stable while ldr_req=1
ldr_ack  out  1  one-clock pulse when the write has completed
core_addr  in  19  arcade ROM fetch address; free-running
core_data  out  8  last fetched byte for core_addr
core_valid  out  1  one-clock pulse when core_data is updated
core_hold  out  1  holds the arcade core in reset during and after loading
cfg_data  out  8  config byte from CFG_ADDR; bits [1:0] drive scandblctrl
cfg_valid  out  1  level; goes high after the boot read and stays high
sram_addr  out  19  SRAM address pins
sram_dout  out  8  SRAM write data
sram_doe  out  1  tri-state enable for sram_dout (1 = drive)
sram_din  in  8  SRAM read data from the pad
sram_we_n  out  1  SRAM write enable, active low

Behaviour:
- Reset values: sram_addr=CFG_ADDR, sram_dout=0, sram_doe=0, sram_we_n=1, ldr_ack=0, core_data=0, core_valid=0, core_hold=1, cfg_data=0, cfg_valid=0. State=BOOT.
- Reset asserted mid-operation: abort immediately. Next clock restores the reset values, so we_n is forced high even if a write was in flight.
- States: BOOT, IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD.
- BOOT:
  - sram_addr=CFG_ADDR; wait RD_CYCLES clocks.
  - Sample sram_din into cfg_data, set cfg_valid=1, go to IDLE.
  - Never re-entered except via reset.
- IDLE arbitration, evaluated every clock. Priority: loader over core.
  - ldr_req=1: latch addr/data, go to WR_SETUP.
  - Otherwise: latch core_addr into sram_addr, go to RD.
- RD:
  - Hold the address RD_CYCLES clocks; on the last one, sample sram_din into core_data and pulse core_valid.
  - Return to IDLE. One core fetch therefore takes RD_CYCLES+1 clocks.
  - A core_addr change during RD is ignored until the next fetch.
- Write sequence:
  - WR_SETUP (1 clk): sram_addr=ldr_addr, sram_dout=ldr_data, sram_doe=1, we_n=1.
  - WR_PULSE (WE_CYCLES clks): we_n=0.
  - WR_HOLD (1 clk): we_n=1, doe still 1. ldr_ack pulses this clock; go to IDLE.
  - sram_doe drops in IDLE. Address and data stay stable across the whole sequence, with no glitch on we_n.
- Back-to-back writes: if ldr_req is still high in IDLE, the next write starts, so the minimum write spacing is WE_CYCLES+3 clocks. The loader must deassert or change its request after ack.
- ldr_req raised while in RD: that fetch completes first. Worst-case write latency is RD_CYCLES+1 clocks.
- core_hold:
  - Set to 1 on WR_SETUP entry.
  - Counter is reloaded with HOLD_CYCLES on every ldr_ack, then decrements each clock while there are no writes.
  - core_hold clears when the counter reaches 0 and cfg_valid=1.
  - After reset with no loads, core_hold clears HOLD_CYCLES clocks after cfg_valid.
- The hold counter width is ceil(log2(HOLD_CYCLES+1)). It saturates at 0 and never wraps.
- No combinational path from inputs to SRAM pins. All SRAM outputs are registered.

Decomposition:
- Shared package (sram_pkg):
  - state encoding enum;
  - SRAM width constants (ADDR_W=19, DATA_W=8);
  - default CFG_ADDR.
- One natural sub-module: sram_hold_timer (reloadable down-counter producing core_hold).
- The FSM and pin registers stay in the top module.

Test Plan:
- Reset, model returns 8'h05 at 19'h08FD5 -> cfg_valid rises RD_CYCLES+1 clocks after reset release; cfg_data=8'h05; we_n stays 1 throughout.
- No loader activity, core_addr=19'h00123, model byte 8'hA7 -> core_valid pulses every 3 clocks (defaults) with core_data=8'hA7; core_hold falls 255 clocks after cfg_valid.
- Loader write addr 19'h01000, data 8'h3C -> sram_addr/dout stable for 5 clocks, we_n low exactly 2 clocks, ldr_ack one pulse; readback via core_addr=19'h01000 returns 8'h3C.
- ldr_req held for 4 consecutive writes while the core also fetches -> writes issued every 5 clocks with no core fetch in between; core_hold=1 until 255 clocks after the 4th ack.
- ldr_req asserted mid-RD -> RD completes with core_valid, then WR_SETUP next clock; no overlap of doe=1 with the read sample.
- Reset asserted during WR_PULSE -> next clock we_n=1, doe=0, state BOOT; ldr_ack never pulses; config re-read.
